// File: rtl/bg_line_prefetch.sv
// Scanline prefetch: copies the next 4-bpp source row from the block ROM into the idle
// bank of a two-bank line buffer and serves palette indices from the displayed bank.
// Optional vertical scroll is enabled by defining BG_VSCROLL_EN (adds scroll_row).
module bg_line_prefetch #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int V_TOTAL   = 525,
    parameter int ROW_BYTES = 160,
    parameter int SRC_ROWS  = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
`ifdef BG_VSCROLL_EN
    input  logic [7:0]  scroll_row,
`endif
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [3:0]  palette_idx,
    output logic        fetch_busy,
    output logic        overrun
);

    localparam logic [7:0] COL_LAST = 8'(ROW_BYTES - 1);
    localparam logic [7:0] ROW_LAST = 8'(SRC_ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } state_t;

    state_t      state_reg, state_next;
    logic        prime_reg;
    logic [7:0]  col_reg;
    logic [15:0] base_reg;
    logic        bank_reg;
    logic        addr_vld_reg;
    logic        wr_vld_reg;
    logic [7:0]  wr_col_reg;
    logic        wr_bank_reg;
    logic        load;
    logic        advance;

    logic [7:0]  line_buf [2][ROW_BYTES];

    // ------------------------------------------------------------------
    // Row selection for the next fetch
    // ------------------------------------------------------------------
    logic        trigger;
    logic        start;
    logic [7:0]  disp_row;
    logic [7:0]  next_row;
    logic [7:0]  start_row;
    logic [7:0]  src_row;
    logic [15:0] start_base;

    assign trigger   = (h_cnt == 10'd0) && !v_cnt[0] && (v_cnt < 10'(V_ACTIVE));
    assign start     = trigger || prime_reg;
    assign disp_row  = v_cnt[8:1];
    assign next_row  = (disp_row == ROW_LAST) ? 8'd0 : disp_row + 8'd1;
    assign start_row = prime_reg ? 8'd0 : next_row;

`ifdef BG_VSCROLL_EN
    logic [7:0] scroll_q_reg;
    logic [8:0] scroll_sum;

    // scroll_q_reg is stored already reduced below SRC_ROWS, so one subtract suffices here.
    assign scroll_sum = {1'b0, start_row} + {1'b0, scroll_q_reg};
    assign src_row    = (scroll_sum >= 9'(SRC_ROWS)) ? 8'(scroll_sum - 9'(SRC_ROWS))
                                                     : scroll_sum[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scroll_q_reg <= 8'd0;
        end else if ((h_cnt == 10'd0) && (v_cnt == 10'(V_TOTAL - 1))) begin
            scroll_q_reg <= (scroll_row >= 8'(SRC_ROWS)) ? scroll_row - 8'(SRC_ROWS)
                                                         : scroll_row;
        end
    end
`else
    assign src_row = start_row;
`endif

    assign start_base = 16'(src_row) * 16'(ROW_BYTES);

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        advance    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (trigger) begin
                    load = 1'b1;
                end else if (col_reg == COL_LAST) begin
                    state_next = ST_DRAIN;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (trigger) begin
                    load       = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign fetch_busy = (state_reg != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            prime_reg    <= 1'b1;
            col_reg      <= 8'd0;
            base_reg     <= 16'd0;
            bank_reg     <= 1'b0;
            rom_addr     <= 16'd0;
            addr_vld_reg <= 1'b0;
            wr_vld_reg   <= 1'b0;
            wr_col_reg   <= 8'd0;
            wr_bank_reg  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_reg <= state_next;
            prime_reg <= 1'b0;
            if (load) begin
                base_reg     <= start_base;
                col_reg      <= 8'd0;
                bank_reg     <= start_row[0];
                rom_addr     <= start_base;
                addr_vld_reg <= 1'b1;
            end else if (advance) begin
                col_reg      <= col_reg + 8'd1;
                rom_addr     <= base_reg + {8'd0, col_reg + 8'd1};
                addr_vld_reg <= 1'b1;
            end else begin
                addr_vld_reg <= 1'b0;
            end
            // ROM data lags its address by one cycle; a restart drops the in-flight byte.
            wr_vld_reg  <= addr_vld_reg && !load;
            wr_col_reg  <= col_reg;
            wr_bank_reg <= bank_reg;
            if (trigger && (state_reg != ST_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld_reg) begin
            line_buf[wr_bank_reg][wr_col_reg] <= rom_data;
        end
    end

    // ------------------------------------------------------------------
    // Display read: bank = row[0], byte column = x>>1, nibble = x[0]
    // ------------------------------------------------------------------
    logic       blank;
    logic       rd_bank;
    logic [7:0] rd_col;
    logic [7:0] rd_byte;

    assign blank   = (h_cnt >= 10'(H_ACTIVE)) || (v_cnt >= 10'(V_ACTIVE));
    assign rd_bank = v_cnt[1];
    assign rd_col  = blank ? 8'd0 : h_cnt[9:2];
    assign rd_byte = line_buf[rd_bank][rd_col];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            palette_idx <= 4'd0;
        end else if (blank) begin
            palette_idx <= 4'd0;
        end else begin
            palette_idx <= h_cnt[1] ? rd_byte[7:4] : rd_byte[3:0];
        end
    end

endmodule

// File: tb/tb_bg_line_prefetch.sv
// Scoreboard bench for bg_line_prefetch: stimulus pushes expected ROM addresses and
// palette indices into queues; a negedge monitor pops and compares them.
module tb_bg_line_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  hc = 10'd700;
    logic [9:0]  vc = 10'd500;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data = 8'd0;
    logic [3:0]  palette_idx;
    logic        fetch_busy;
    logic        overrun;
`ifdef BG_VSCROLL_EN
    logic [7:0]  scroll_row = 8'd0;
`endif

    bg_line_prefetch dut (
        .clk         (clk),
        .rst         (rst),
        .h_cnt       (hc),
        .v_cnt       (vc),
`ifdef BG_VSCROLL_EN
        .scroll_row  (scroll_row),
`endif
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .palette_idx (palette_idx),
        .fetch_busy  (fetch_busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    logic [7:0] rom_mem [65536];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // Reference model: what each line-buffer bank should hold after a completed fetch.
    logic [7:0] mbuf [2][160];
    bit         mvalid [2];
    int         mscroll = 0;
    int         pend_row = 0;
    int         pend_bank = 0;

    int addr_q[$];
    int pix_q[$];
    int checks = 0;
    int errors = 0;
    bit busy_prev = 1'b0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (fetch_busy) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL busy_extra actual=busy rom_addr=%0d required=idle at %0t",
                             rom_addr, $time);
                end else begin
                    check("rom_addr", int'(rom_addr), addr_q.pop_front());
                end
            end else if (busy_prev) begin
                check("busy_len_left", addr_q.size(), 0);
            end
            busy_prev = fetch_busy;
            if (pix_q.size() != 0) check("palette_idx", int'(palette_idx), pix_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(int src, int bank);
        addr_q.delete();
        for (int k = 0; k <= 160; k++) addr_q.push_back(src * 160 + ((k > 159) ? 159 : k));
        mvalid[bank] = 1'b0;
        pend_row  = src;
        pend_bank = bank;
    endtask

    task automatic trigger(int v);
        int nr;
        hc = 10'd0;
        vc = 10'(v);
        tick();
        nr = ((v / 2) + 1) % 240;
        expect_fetch((nr + mscroll) % 240, nr % 2);
        hc = 10'd700;
        vc = 10'd500;
    endtask

    task automatic wait_done();
        int n = 0;
        while (fetch_busy && n < 400) begin
            tick();
            n++;
        end
        check("fetch_done", int'(fetch_busy), 0);
        for (int c = 0; c < 160; c++) mbuf[pend_bank][c] = rom_mem[pend_row * 160 + c];
        mvalid[pend_bank] = 1'b1;
    endtask

    task automatic release_rst();
        rst = 1'b0;
        tick();
        expect_fetch(mscroll % 240, 0);
    endtask

    task automatic pix(int h, int v);
        int x;
        int b;
        logic [7:0] byte_v;
        hc = 10'(h);
        vc = 10'(v);
        tick();
        if (h >= 640 || v >= 480) begin
            pix_q.push_back(0);
        end else begin
            x = h / 2;
            b = (v / 2) % 2;
            if (mvalid[b]) begin
                byte_v = mbuf[b][x / 2];
                pix_q.push_back((x % 2) ? int'(byte_v[7:4]) : int'(byte_v[3:0]));
            end
        end
    endtask

    task automatic pix_scan(int n);
        for (int i = 0; i < n; i++) pix(int'($urandom_range(1, 799)), int'($urandom_range(0, 524)));
        hc = 10'd700;
        vc = 10'd500;
        tick();
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_rom_addr"}, int'(rom_addr), 0);
        check({tag, "_palette"}, int'(palette_idx), 0);
        check({tag, "_busy"}, int'(fetch_busy), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) rom_mem[a] = 8'($urandom);
        mvalid[0] = 1'b0;
        mvalid[1] = 1'b0;

        // Reset state and prime fetch of row 0 into bank 0
        repeat (3) tick();
        check_reset_outputs("reset");
        release_rst();
        wait_done();
        pix_scan(120);

        // Row 1 into bank 1, then targeted display reads on line 2
        trigger(0);
        wait_done();
        pix(20, 2);
        pix(22, 2);
        pix(650, 2);
        pix(639, 3);
        pix_scan(120);

        // Line 10 -> row 6 (addresses 960..1119, bank 0); line 478 -> row 0 wrap
        trigger(10);
        wait_done();
        pix_scan(60);
        trigger(478);
        wait_done();
        pix_scan(60);

        // Random triggers over the visible range
        for (int i = 0; i < 6; i++) begin
            trigger(2 * int'($urandom_range(0, 239)));
            wait_done();
            pix_scan(60);
        end

        // Retrigger 50 cycles into a fetch: restart at the new base, sticky overrun
        check("overrun_before", int'(overrun), 0);
        trigger(10);
        repeat (49) tick();
        trigger(20);
        mvalid[0] = 1'b0;
        check("overrun_set", int'(overrun), 1);
        wait_done();
        repeat (20) tick();
        check("overrun_sticky", int'(overrun), 1);
        pix_scan(60);

        // Reset mid-fetch: outputs clear at once, prime fetch follows release
        trigger(30);
        repeat (30) tick();
        addr_q.delete();
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        mvalid[0] = 1'b0;
        mvalid[1] = 1'b0;
        mscroll   = 0;
        repeat (2) tick();
        release_rst();
        wait_done();
        pix_scan(60);

`ifdef BG_VSCROLL_EN
        // scroll 200 latched on the last frame line; line 100 fetches row (51+200) mod 240 = 11
        scroll_row = 8'd200;
        hc = 10'd0;
        vc = 10'd524;
        tick();
        mscroll = 200;
        hc = 10'd700;
        vc = 10'd500;
        scroll_row = 8'($urandom);
        tick();
        trigger(100);
        wait_done();
        pix_scan(60);
        for (int i = 0; i < 4; i++) begin
            scroll_row = 8'($urandom);
            mscroll = int'(scroll_row);
            hc = 10'd0;
            vc = 10'd524;
            tick();
            hc = 10'd700;
            vc = 10'd500;
            trigger(2 * int'($urandom_range(0, 239)));
            wait_done();
            pix_scan(40);
        end
`endif

        repeat (4) tick();
        check("addr_q_left", addr_q.size(), 0);
        check("pix_q_left", pix_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
